fifo: RTL and testbench
=======================

# fifo

Synchronous single-clock first-in/first-out buffer used as a generic storage element between producer and consumer logic in the data-transfer protocol blocks. Each cycle it accepts one write via `push` and/or one read via `pop`, storing up to `N_SIZE` words of `N_BITS` each. It exposes `full` and `empty` status flags and presents popped data on a registered output.

## Interface
- `N_BITS`, default 8: data word width in bits (≥1).
- `N_SIZE`, default 4: storage depth in words (≥2; any integer, not restricted to powers of two).
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `push`  in  1: write request; `data_in` is stored at the next rising edge if accepted.
- `pop`  in  1: read request; the oldest word is moved to `data_out` at the next rising edge if accepted.
- `data_in`  in  `N_BITS`: write data.
- `data_out`  out  `N_BITS`: registered read data; holds its value between accepted pops.
- `full`  out  1: high when the FIFO holds `N_SIZE` words.
- `empty`  out  1: high when the FIFO holds 0 words.

## Operation
- State:
  - Storage array of `N_SIZE` × `N_BITS`.
  - Write pointer and read pointer, each `$clog2(N_SIZE)` bits.
  - Occupancy count, 0..`N_SIZE`, `$clog2(N_SIZE+1)` bits.
- An accepted push writes `data_in` at the write pointer, advances the write pointer and increments the count.
- An accepted pop loads `data_out` from the read pointer, advances the read pointer and decrements the count.
- Pointer wrap: a pointer at `N_SIZE-1` advances to 0. This is an explicit compare, so non-power-of-two depths are supported.
- `push` is accepted iff not full, or if a pop is accepted in the same cycle while full.
- `pop` is accepted iff not empty. Pop on empty is ignored: `data_out`, pointers and count are unchanged.
- Push on full without pop is dropped silently: no storage, pointer or count change.
- Simultaneous push and pop:
  - Neither full nor empty: both are performed and the count is unchanged.
  - Full: the pop is performed, the push is accepted into the freed slot, the count stays `N_SIZE`, and `full` stays high.
  - Empty: only the push is performed. There is no fall-through, `data_out` is unchanged, and the count becomes 1.
- `full` = (count == `N_SIZE`); `empty` = (count == 0). Both are decoded from registered count only, with no combinational path from `push`/`pop`.
- Storage contents are not reset and are never read while invalid.

## Timing
- Reset (`rst`=1 at a rising edge): pointers=0, count=0, `data_out`=0, `empty`=1, `full`=0. Reset overrides push and pop in the same cycle.
- Reset asserted mid-operation discards all stored words. The first accepted push after reset is the next word popped.
- Write-to-read latency:
  - A word pushed at edge N can be popped at edge N+1 at the earliest.
  - It is visible on `data_out` just after that pop edge.
- Flag latency: `empty`/`full` update in the same cycle the count changes, i.e. just after the edge of the accepted operation.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset then single word: assert `rst`, release it, push 0xFF for one cycle, idle one cycle, then pop once. Required: `data_out`=0xFF after the pop edge, and `empty`=1 afterwards.
- Underflow: a further pop on empty. Required: `data_out` stays 0xFF, `empty` stays 1, and `full` stays 0.
- Fill and overflow: push 0x1F, 0x2F, 0x3F, 0x4F on consecutive cycles. Required: `full`=1 after the 4th edge. A 5th push of 0x5F is dropped and `full` stays 1.
- Drain with wrap: pop on consecutive cycles. Required:
  - `data_out` = 0x1F, 0x2F, 0x3F, 0x4F on successive cycles, never 0x5F.
  - `empty`=1 after the 4th pop.
  - Extra pops leave `data_out`=0x4F.
- Simultaneous push/pop starting from empty: push 0x6F, 0x7F, 0x8F, 0x9F with `pop`=1 every cycle. Required:
  - First cycle: push only, count becomes 1, `data_out` unchanged.
  - Then `data_out` = 0x6F, 0x7F, 0x8F on successive edges, with count held at 1 and `empty`=0.
  - A final pop yields 0x9F and sets `empty`=1.
- Push/pop when full, plus reset mid-operation: fill to 4 words, then push+pop together.
  - Required: the oldest word appears on `data_out`, the new word is retained, and `full` stays 1.
  - Then assert `rst`. Required: `empty`=1, `full`=0, `data_out`=0 on the next cycle.

Source files
------------

// File: rtl/fifo.sv
// ----------------------------------------------------------------------------
// fifo
//
// Synchronous single-clock first-in/first-out buffer. It sits between a
// producer and a consumer and accepts at most one write and one read per
// clock. Popped data is presented on a registered output that holds its
// value between accepted pops. Any depth of two or more words is supported,
// not just powers of two, because pointer wrap is an explicit compare.
//
// Parameters
//   N_BITS   : data word width in bits (>= 1)
//   N_SIZE   : storage depth in words (>= 2)
//
// Ports
//   clk      : in  1       clock, all state changes on the rising edge
//   rst      : in  1       synchronous active-high reset
//   push     : in  1       write request, data_in stored if accepted
//   pop      : in  1       read request, oldest word moved to data_out
//   data_in  : in  N_BITS  write data
//   data_out : out N_BITS  registered read data
//   full     : out 1       FIFO holds N_SIZE words
//   empty    : out 1       FIFO holds no words
// ----------------------------------------------------------------------------
module fifo #(
  parameter int N_BITS = 8,
  parameter int N_SIZE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [N_BITS-1:0] data_in,
  output logic [N_BITS-1:0] data_out,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(N_SIZE);
  localparam int CNT_W = $clog2(N_SIZE + 1);

  localparam logic [PTR_W-1:0] PTR_ZERO = '0;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_SIZE);

  logic [N_BITS-1:0] mem_q [N_SIZE];

  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [N_BITS-1:0] dataOut_q, dataOut_d;

  logic pushAccept;
  logic popAccept;
  logic isFull;
  logic isEmpty;

  // Advance a pointer by one slot, wrapping from the last slot back to zero.
  // The compare against N_SIZE-1 keeps odd depths from walking off the end.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return PTR_ZERO;
    end
    return ptr + PTR_ONE;
  endfunction

  // Status flags come only from the registered count, so they never depend
  // combinationally on push or pop.
  assign isFull  = (count_q == CNT_FULL);
  assign isEmpty = (count_q == CNT_ZERO);

  // A pop needs at least one stored word. A push needs a free slot, except
  // that when full a same-cycle pop frees the slot the push will use.
  assign popAccept  = pop  && !isEmpty;
  assign pushAccept = push && (!isFull || popAccept);

  // Next-state for pointers, occupancy and the output register. On a
  // push-while-empty only the push is accepted, so data_out keeps its old
  // value and there is no fall-through path from data_in.
  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    dataOut_d = dataOut_q;

    if (pushAccept) begin
      wrPtr_d = nextPtr(wrPtr_q);
    end

    if (popAccept) begin
      rdPtr_d   = nextPtr(rdPtr_q);
      dataOut_d = mem_q[rdPtr_q];
    end

    unique case ({pushAccept, popAccept})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state register. Reset wins over any push or pop in the same
  // cycle and discards every stored word by clearing count and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q   <= PTR_ZERO;
      rdPtr_q   <= PTR_ZERO;
      count_q   <= CNT_ZERO;
      dataOut_q <= '0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      dataOut_q <= dataOut_d;
    end
  end

  // Storage array has no reset: a slot is only read after it has been
  // written, and the count guards against reading stale entries.
  always_ff @(posedge clk) begin
    if (!rst && pushAccept) begin
      mem_q[wrPtr_q] <= data_in;
    end
  end

  assign data_out = dataOut_q;
  assign full     = isFull;
  assign empty    = isEmpty;

endmodule

// File: tb/tb_fifo.sv
// ----------------------------------------------------------------------------
// tb_fifo
//
// Directed testbench for fifo with the default 8-bit by 4-word geometry.
// Inputs change between edges, each step spans one rising edge, and outputs
// are compared 1 time unit after that edge against hand-computed values.
// ----------------------------------------------------------------------------
module tb_fifo;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic       full;
  logic       empty;

  int checks;
  int errors;

  fifo #(
    .N_BITS(8),
    .N_SIZE(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .data_in (dataIn),
    .data_out(dataOut),
    .full    (full),
    .empty   (empty)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the rising edge take them, then settle.
  task automatic applyStimulus(input logic r, input logic pu, input logic po,
                               input logic [7:0] d);
    rst    = r;
    push   = pu;
    pop    = po;
    dataIn = d;
    @(posedge clk);
    #1;
  endtask

  // Compare all three observable outputs against the expected values.
  task automatic checkOutput(input string tag, input logic [7:0] expData,
                             input logic expFull, input logic expEmpty);
    checks++;
    assert (dataOut === expData) else begin
      errors++;
      $error("[TB] FAIL %s data_out: observed %h expected %h", tag, dataOut, expData);
    end
    checks++;
    assert (full === expFull) else begin
      errors++;
      $error("[TB] FAIL %s full: observed %b expected %b", tag, full, expFull);
    end
    checks++;
    assert (empty === expEmpty) else begin
      errors++;
      $error("[TB] FAIL %s empty: observed %b expected %b", tag, empty, expEmpty);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    dataIn = 8'h00;
    @(negedge clk);

    // Reset, then a single word through.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00); checkOutput("reset",       8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF); checkOutput("push FF",     8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00); checkOutput("idle",        8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00); checkOutput("pop FF",      8'hFF, 1'b0, 1'b1);

    // Underflow is ignored.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00); checkOutput("underflow",   8'hFF, 1'b0, 1'b1);

    // Fill and overflow.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h1F); checkOutput("fill 1",      8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h2F); checkOutput("fill 2",      8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h3F); checkOutput("fill 3",      8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h4F); checkOutput("fill 4",      8'hFF, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h5F); checkOutput("overflow",    8'hFF, 1'b1, 1'b0);

    // Drain across the pointer wrap; the dropped 0x5F must never appear.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00); checkOutput("drain 1",     8'h1F, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00); checkOutput("drain 2",     8'h2F, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00); checkOutput("drain 3",     8'h3F, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00); checkOutput("drain 4",     8'h4F, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00); checkOutput("drain extra", 8'h4F, 1'b0, 1'b1);

    // Simultaneous push/pop from empty: first cycle is push only.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h6F); checkOutput("pp 6F",       8'h4F, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h7F); checkOutput("pp 7F",       8'h6F, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h8F); checkOutput("pp 8F",       8'h7F, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h9F); checkOutput("pp 9F",       8'h8F, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00); checkOutput("pp last",     8'h9F, 1'b0, 1'b1);

    // Push/pop together while full.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hA1); checkOutput("refill 1",    8'h9F, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hA2); checkOutput("refill 2",    8'h9F, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hA3); checkOutput("refill 3",    8'h9F, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hA4); checkOutput("refill 4",    8'h9F, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hB5); checkOutput("full pp",     8'hA1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00); checkOutput("post A2",     8'hA2, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00); checkOutput("post A3",     8'hA3, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00); checkOutput("post A4",     8'hA4, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00); checkOutput("post B5",     8'hB5, 1'b0, 1'b1);

    // Reset mid-operation, with push and pop also asserted.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hD1); checkOutput("pre D1",      8'hB5, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hD2); checkOutput("pre D2",      8'hB5, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hD3); checkOutput("mid reset",   8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hE1); checkOutput("after rst",   8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00); checkOutput("pop E1",      8'hE1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
